// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between the core's fetch and data sides: data access
// first (if any), then the fetch at the current PC, then a one-cycle valid pulse.
module rv32i_mem_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] imem_add_i,
   output logic [31:0] imem_data_o,
   output logic        imem_valid_o,
   input  logic [31:0] dmem_add_i,
   input  logic [31:0] dmem_di_i,
   input  logic        dmem_we_i,
   input  logic        dmem_re_i,
   input  logic [3:0]  dmem_ble_i,
   output logic [31:0] dmem_do_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_add_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        bus_err_o
);

   localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH, S_DONE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          req_n, we_n, err_n;
   logic [3:0]    be_n;
   logic [31:0]   add_n, wdata_n, idata_n, ddata_n;
   logic          timeout;

   assign timeout      = (cnt == CW'(ACK_TIMEOUT - 1)) && !mem_ack_i;
   assign imem_valid_o = (state == S_DONE);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      req_n   = mem_req_o;
      we_n    = mem_we_o;
      be_n    = mem_be_o;
      add_n   = mem_add_o;
      wdata_n = mem_wdata_o;
      idata_n = imem_data_o;
      ddata_n = dmem_do_o;
      err_n   = bus_err_o;
      case (state)
         S_IDLE: begin
            req_n = 1'b1;
            cnt_n = '0;
            if (dmem_we_i || dmem_re_i) begin
               state_n = S_DATA;
               we_n    = dmem_we_i;
               be_n    = dmem_we_i ? dmem_ble_i : 4'hF;
               add_n   = dmem_add_i & ~32'h3;
               wdata_n = dmem_di_i;
            end else begin
               state_n = S_FETCH;
               we_n    = 1'b0;
               be_n    = 4'hF;
               add_n   = imem_add_i & ~32'h3;
            end
         end
         S_DATA: begin
            if (mem_ack_i || timeout) begin
               // mem_we_o still holds the kind of the access being completed
               if (!mem_we_o) ddata_n = mem_ack_i ? mem_rdata_i : '0;
               if (!mem_ack_i) err_n = 1'b1;
               state_n = S_FETCH;
               cnt_n   = '0;
               we_n    = 1'b0;
               be_n    = 4'hF;
               add_n   = imem_add_i & ~32'h3;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_FETCH: begin
            if (mem_ack_i || timeout) begin
               idata_n = mem_ack_i ? mem_rdata_i : NOP_INSTR;
               if (!mem_ack_i) err_n = 1'b1;
               state_n = S_DONE;
               req_n   = 1'b0;
               we_n    = 1'b0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            req_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= S_IDLE;
         cnt         <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
         mem_add_o   <= '0;
         mem_wdata_o <= '0;
         imem_data_o <= NOP_INSTR;
         dmem_do_o   <= '0;
         bus_err_o   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         mem_req_o   <= req_n;
         mem_we_o    <= we_n;
         mem_be_o    <= be_n;
         mem_add_o   <= add_n;
         mem_wdata_o <= wdata_n;
         imem_data_o <= idata_n;
         dmem_do_o   <= ddata_n;
         bus_err_o   <= err_n;
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench: a transaction-level model predicts each memory access, the
// result registers and the error flag, and is checked on every falling edge.
module tb_rv32i_mem_arbiter;

   localparam int          TO  = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      bit          is_data;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;   // request cycles before ack, <0 = never ack
      logic [31:0] rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_add, imem_data, dmem_add, dmem_di, dmem_do;
   logic [31:0] mem_add, mem_wdata, mem_rdata;
   logic        imem_valid, dmem_we, dmem_re, mem_req, mem_we, mem_ack, bus_err;
   logic [3:0]  dmem_ble, mem_be;

   logic        resp_ack, man_ack;
   logic [31:0] resp_rdata, man_rdata;
   bit          model_on;

   assign mem_ack   = model_on ? resp_ack : man_ack;
   assign mem_rdata = model_on ? resp_rdata : man_rdata;

   always #5 clk = ~clk;

   rv32i_mem_arbiter #(.ACK_TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
      .clk_i(clk), .reset_i(reset),
      .imem_add_i(imem_add), .imem_data_o(imem_data), .imem_valid_o(imem_valid),
      .dmem_add_i(dmem_add), .dmem_di_i(dmem_di), .dmem_we_i(dmem_we),
      .dmem_re_i(dmem_re), .dmem_ble_i(dmem_ble), .dmem_do_o(dmem_do),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_add_o(mem_add), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .mem_ack_i(mem_ack), .bus_err_o(bus_err)
   );

   int          checks, fails;
   txn_t        q[$];
   int          cnt, pulses;
   bit          prev_ack, prev_valid, in_done;
   logic [31:0] exp_imem, exp_dmem;
   logic        exp_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cyc(input int w);
      return (w < 0) ? TO : w + 1;
   endfunction

   // Model step: retire the finished access, then play memory and check the bus.
   task automatic compare_cycle();
      txn_t t;
      if (!model_on) begin
         cnt = 0; prev_ack = 0; prev_valid = 0; resp_ack = 1'b0; resp_rdata = '0;
         return;
      end
      if (q.size() > 0 && (prev_ack || (q[0].waits < 0 && cnt == TO))) begin
         t = q.pop_front();
         if (prev_ack) begin
            if (t.is_data && !t.we) exp_dmem = t.rdata;
            if (!t.is_data) exp_imem = t.rdata;
         end else begin
            exp_err = 1'b1;
            if (t.is_data && !t.we) exp_dmem = '0;
            if (!t.is_data) exp_imem = NOP;
         end
         cnt = 0;
      end
      prev_ack = 0;
      resp_ack = 1'b0;
      if (mem_req) begin
         if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_req: got req=1 addr %h expected no request at %0t", mem_add, $time);
         end else begin
            chk_bit("req_we", mem_we, q[0].we);
            chk("req_be", {28'b0, mem_be}, {28'b0, q[0].be});
            chk("req_addr", mem_add, q[0].addr);
            if (q[0].we) chk("req_wdata", mem_wdata, q[0].wdata);
            if (cnt == q[0].waits) begin
               resp_ack = 1'b1; resp_rdata = q[0].rdata; prev_ack = 1;
            end
            cnt++;
         end
      end
      if (imem_valid) begin
         chk_bit("valid_back_to_back", prev_valid, 1'b0);
         pulses++;
      end
      prev_valid = imem_valid;
      chk("imem_data", imem_data, exp_imem);
      chk("dmem_do", dmem_do, exp_dmem);
      chk_bit("bus_err", bus_err, exp_err);
   endtask

   task automatic start_model();
      q.delete();
      exp_imem = NOP; exp_dmem = '0; exp_err = 1'b0;
      in_done = 0;
      model_on = 1;
   endtask

   task automatic run_instr(input logic [31:0] pc, input logic re, input logic we,
                            input logic [3:0] ble, input logic [31:0] dadd,
                            input logic [31:0] di, input int dwait, input logic [31:0] drd,
                            input int fwait, input logic [31:0] frd);
      txn_t t;
      int   n, exp_n;
      bit   seen;
      if (in_done) begin @(posedge clk); #1; end
      imem_add = pc; dmem_re = re; dmem_we = we; dmem_ble = ble;
      dmem_add = dadd; dmem_di = di;
      exp_n = 2 + cyc(fwait);
      if (re || we) begin
         t.is_data = 1; t.we = we; t.be = we ? ble : 4'hF;
         t.addr = {dadd[31:2], 2'b00}; t.wdata = di; t.waits = dwait; t.rdata = drd;
         q.push_back(t);
         exp_n += cyc(dwait);
      end
      t.is_data = 0; t.we = 0; t.be = 4'hF; t.addr = {pc[31:2], 2'b00};
      t.wdata = '0; t.waits = fwait; t.rdata = frd;
      q.push_back(t);
      n = 1; seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk); #1;
         n++;
         seen = imem_valid;
      end
      chk_bit("valid_seen", seen, 1'b1);
      chk("latency", n, exp_n);
      in_done = 1;
   endtask

   initial begin
      int p0;
      checks = 0; fails = 0; pulses = 0; cnt = 0;
      model_on = 0; man_ack = 1'b0; man_rdata = '0; resp_ack = 1'b0; resp_rdata = '0;
      imem_add = '0; dmem_add = '0; dmem_di = '0; dmem_we = 1'b0; dmem_re = 1'b0;
      dmem_ble = '0; reset = 1'b1;
      fork
         forever begin @(negedge clk); compare_cycle(); end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_req", mem_req, 1'b0);
      chk_bit("rst_we", mem_we, 1'b0);
      chk("rst_be", {28'b0, mem_be}, 32'h0);
      chk("rst_add", mem_add, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk_bit("rst_valid", imem_valid, 1'b0);
      chk("rst_imem", imem_data, 32'h0000_0013);
      chk("rst_dmem", dmem_do, 32'h0);
      chk_bit("rst_err", bus_err, 1'b0);
      reset = 1'b0;
      start_model();

      // plain fetch, zero wait states
      run_instr(32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0050_0093);
      chk("t1_imem", imem_data, 32'h0050_0093);
      chk("t1_dmem", dmem_do, 32'h0);
      // load with 2 wait states
      run_instr(32'h104, 1, 0, 4'h0, 32'h2006, 32'h0, 2, 32'hDEAD_BEEF, 0, 32'h00A0_0113);
      chk("t2_dmem", dmem_do, 32'hDEAD_BEEF);
      chk("t2_imem", imem_data, 32'h00A0_0113);
      // we and re together: a store
      run_instr(32'h108, 1, 1, 4'b0011, 32'h3000, 32'h1234_ABCD, 1, 32'h5555_5555, 1, 32'h0011_2023);
      chk("t3_dmem", dmem_do, 32'hDEAD_BEEF);
      // fetch never acked
      run_instr(32'h10C, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, -1, 32'hFFFF_FFFF);
      chk("t4_imem", imem_data, 32'h0000_0013);
      chk_bit("t4_err", bus_err, 1'b1);
      // store timeout leaves load data alone
      run_instr(32'h110, 0, 1, 4'hF, 32'h3100, 32'h0BAD_F00D, -1, 32'h0, 0, 32'h0000_0033);
      chk("t5_dmem", dmem_do, 32'hDEAD_BEEF);
      chk_bit("t5_err", bus_err, 1'b1);
      // load timeout zeroes load data
      run_instr(32'h114, 1, 0, 4'h0, 32'h4000, 32'h0, -1, 32'h0, 0, 32'h0000_00B3);
      chk("t6_dmem", dmem_do, 32'h0);
      chk("t6_imem", imem_data, 32'h0000_00B3);

      // reset in the middle of a data wait, with a late ack
      @(posedge clk); #1;
      model_on = 0; q.delete();
      dmem_re = 1'b1; dmem_we = 1'b0; dmem_add = 32'h5000; man_ack = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk_bit("t7_req_before", mem_req, 1'b1);
      reset = 1'b1; man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      chk_bit("t7_req", mem_req, 1'b0);
      chk_bit("t7_valid", imem_valid, 1'b0);
      chk_bit("t7_err", bus_err, 1'b0);
      chk("t7_dmem", dmem_do, 32'h0);
      chk("t7_imem", imem_data, 32'h0000_0013);
      reset = 1'b0; man_ack = 1'b0; dmem_re = 1'b0;
      start_model();

      // back-to-back instructions, loads on every other one
      p0 = pulses;
      for (int i = 0; i < 10; i++)
         run_instr(32'h200 + 32'(4 * i), (i % 2 == 0), 1'b0, 4'hF, 32'h6000 + 32'(8 * i + 1),
                   32'h0, i % 3, 32'hA000_0000 + 32'(i), (i + 1) % 2, 32'h0000_0013 + 32'(i << 7));
      @(posedge clk); #1;
      chk("t8_pulses", pulses - p0, 32'd10);
      chk("t8_dmem", dmem_do, 32'hA000_0008);
      chk("t8_imem", imem_data, 32'h0000_0493);

      model_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
